// File: rtl/line_tracker_ctrl.sv
// N-sensor line tracker: synchroniser, per-channel debounce, signed steering error
// and a TRACK/HOLD/LOST controller feeding the motor mixer and status display.
module line_tracker_ctrl #(
    parameter int unsigned N_SENSORS    = 3,
    parameter int unsigned DEBOUNCE_CYC = 4,
    parameter int unsigned LOST_TIMEOUT = 1000,
    parameter bit          ACTIVE_LOW   = 1'b1,
    localparam int unsigned STEER_W     = $clog2(N_SENSORS) + 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_SENSORS-1:0]      sensor_raw,
    output logic [N_SENSORS-1:0]      on_line,
    output logic signed [STEER_W-1:0] steer,
    output logic [1:0]                state,
    output logic                      lost,
    output logic                      steer_chg
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC + 1) : 1;
    localparam int unsigned TMR_W = $clog2(LOST_TIMEOUT);

    localparam logic [N_SENSORS-1:0]      OFF_LVL    = {N_SENSORS{ACTIVE_LOW}};
    localparam logic [CNT_W-1:0]          CNT_LAST   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [TMR_W-1:0]          TIMER_LAST = TMR_W'(LOST_TIMEOUT - 1);
    localparam logic signed [STEER_W-1:0] STEER_MAX  = STEER_W'(int'(N_SENSORS) - 1);
    localparam logic signed [STEER_W-1:0] STEER_MIN  = STEER_W'(1 - int'(N_SENSORS));

    typedef enum logic [1:0] {
        StTrack = 2'b00,
        StHold  = 2'b01,
        StLost  = 2'b10
    } state_e;

    logic [N_SENSORS-1:0]             sync1_q, sync2_q;
    logic [N_SENSORS-1:0]             filt_q, filt_d;
    logic [N_SENSORS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    state_e                           state_q, state_d;
    logic signed [STEER_W-1:0]        steer_q, steer_d;
    logic [TMR_W-1:0]                 timer_q, timer_d;
    logic                             steer_chg_q, lost_q;
    logic signed [STEER_W-1:0]        err;
    logic                             any_on;
    int                               lo_idx, hi_idx;

    // Debounce: a filtered bit flips only after DEBOUNCE_CYC consecutive differing samples.
    always_comb begin
        filt_d = filt_q;
        cnt_d  = cnt_q;
        for (int i = 0; i < int'(N_SENSORS); i++) begin
            if (sync2_q[i] == filt_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                filt_d[i] = sync2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    assign on_line = filt_q ^ OFF_LVL;
    assign any_on  = |on_line;

    // Outermost set sensors define the error, so symmetric split patterns read as centred.
    always_comb begin
        lo_idx = 0;
        hi_idx = 0;
        for (int i = int'(N_SENSORS) - 1; i >= 0; i--) begin
            if (on_line[i]) lo_idx = i;
        end
        for (int i = 0; i < int'(N_SENSORS); i++) begin
            if (on_line[i]) hi_idx = i;
        end
        err = STEER_W'(lo_idx + hi_idx - (int'(N_SENSORS) - 1));
    end

    always_comb begin
        state_d = state_q;
        steer_d = steer_q;
        timer_d = timer_q;
        unique case (state_q)
            StTrack: begin
                if (any_on) begin
                    steer_d = err;
                end else begin
                    state_d = StHold;
                    timer_d = '0;
                    if (steer_q[STEER_W-1]) begin
                        steer_d = STEER_MIN;
                    end else if (steer_q != '0) begin
                        steer_d = STEER_MAX;
                    end else begin
                        steer_d = '0;
                    end
                end
            end
            StHold: begin
                if (any_on) begin
                    state_d = StTrack;
                    steer_d = err;
                end else if (timer_q == TIMER_LAST) begin
                    state_d = StLost;
                    steer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            StLost: begin
                if (any_on) begin
                    state_d = StTrack;
                    steer_d = err;
                end else begin
                    steer_d = '0;
                end
            end
            default: begin
                state_d = StTrack;
                steer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= OFF_LVL;
            sync2_q     <= OFF_LVL;
            filt_q      <= OFF_LVL;
            cnt_q       <= '0;
            state_q     <= StTrack;
            steer_q     <= '0;
            timer_q     <= '0;
            steer_chg_q <= 1'b0;
            lost_q      <= 1'b0;
        end else begin
            sync1_q     <= sensor_raw;
            sync2_q     <= sync1_q;
            filt_q      <= filt_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            steer_q     <= steer_d;
            timer_q     <= timer_d;
            steer_chg_q <= (steer_d != steer_q);
            lost_q      <= (state_d == StLost);
        end
    end

    assign steer     = steer_q;
    assign state     = state_q;
    assign lost      = lost_q;
    assign steer_chg = steer_chg_q;

endmodule

// File: tb/tb_line_tracker_ctrl.sv
// Bench for line_tracker_ctrl: default 3-sensor instance plus a fast 5-sensor instance.
module tb_line_tracker_ctrl;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        raw;
    logic [2:0]        on_line;
    logic signed [2:0] steer;
    logic [1:0]        state;
    logic              lost;
    logic              steer_chg;

    logic              rst5;
    logic [4:0]        raw5;
    logic [4:0]        on_line5;
    logic signed [3:0] steer5;
    logic [1:0]        state5;
    logic              lost5;
    logic              steer_chg5;

    int n_tests = 0;
    int n_fail  = 0;
    int chg_cnt = 0;
    int lost_cnt = 0;

    typedef struct {
        logic [2:0] raw;
        logic [2:0] on_line;
        int         steer;
        logic [1:0] state;
        int         pulses;
    } vec_t;

    vec_t tbl [13];
    vec_t sb_q [$];

    always #5 clk = ~clk;

    line_tracker_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .sensor_raw (raw),
        .on_line    (on_line),
        .steer      (steer),
        .state      (state),
        .lost       (lost),
        .steer_chg  (steer_chg)
    );

    line_tracker_ctrl #(
        .N_SENSORS    (5),
        .DEBOUNCE_CYC (1),
        .LOST_TIMEOUT (4),
        .ACTIVE_LOW   (1'b1)
    ) dut5 (
        .clk        (clk),
        .rst        (rst5),
        .sensor_raw (raw5),
        .on_line    (on_line5),
        .steer      (steer5),
        .state      (state5),
        .lost       (lost5),
        .steer_chg  (steer_chg5)
    );

    // Pulses are one cycle wide, so one sample per cycle counts each exactly once.
    always @(negedge clk) begin
        if (steer_chg === 1'b1) chg_cnt++;
        if (lost === 1'b1) lost_cnt++;
    end

    task automatic check(input string name, input logic signed [31:0] act,
                         input logic signed [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        vec_t e;
        int   c0;
        int   l0;
        int   dev;

        tbl[0]  = '{3'b101, 3'b010,  0, 2'b00, 0};
        tbl[1]  = '{3'b011, 3'b100,  2, 2'b00, 1};
        tbl[2]  = '{3'b110, 3'b001, -2, 2'b00, 1};
        tbl[3]  = '{3'b100, 3'b011, -1, 2'b00, 1};
        tbl[4]  = '{3'b000, 3'b111,  0, 2'b00, 1};
        tbl[5]  = '{3'b010, 3'b101,  0, 2'b00, 0};
        tbl[6]  = '{3'b001, 3'b110,  1, 2'b00, 1};
        tbl[7]  = '{3'b111, 3'b000,  2, 2'b01, 1};
        tbl[8]  = '{3'b101, 3'b010,  0, 2'b00, 1};
        tbl[9]  = '{3'b111, 3'b000,  0, 2'b01, 0};
        tbl[10] = '{3'b011, 3'b100,  2, 2'b00, 1};
        tbl[11] = '{3'b111, 3'b000,  2, 2'b01, 0};
        tbl[12] = '{3'b110, 3'b001, -2, 2'b00, 1};

        rst  = 1'b1;
        rst5 = 1'b1;
        raw  = 3'b101;
        raw5 = 5'b01111;
        step(3);
        check("rst on_line", on_line, 0);
        check("rst steer", steer, 0);
        check("rst state", state, 0);
        check("rst lost", lost, 0);
        check("rst steer_chg", steer_chg, 0);

        // Centre line present from edge 0: HOLD briefly, TRACK at edge 6, no pulse.
        c0  = chg_cnt;
        rst = 1'b0;
        step(1);
        check("startup state e0", state, 1);
        step(4);
        check("startup on_line e4", on_line, 0);
        step(1);
        check("startup on_line e5", on_line, 3'b010);
        check("startup state e5", state, 1);
        step(1);
        check("startup state e6", state, 0);
        check("startup steer e6", steer, 0);
        step(2);
        check("startup pulses", chg_cnt - c0, 0);

        // Right then left, exact latency.
        raw = 3'b011;
        step(6);
        check("right steer e5", steer, 0);
        step(1);
        check("right steer e6", steer, 2);
        check("right chg e6", steer_chg, 1);
        step(1);
        check("right chg e7", steer_chg, 0);
        step(4);
        raw = 3'b110;
        step(7);
        check("left steer e6", steer, -2);
        check("left chg e6", steer_chg, 1);
        step(5);

        // 3-cycle glitch must not reach the filtered map.
        raw = 3'b101;
        step(12);
        c0  = chg_cnt;
        dev = 0;
        raw = 3'b001;
        step(3);
        raw = 3'b101;
        for (int k = 0; k < 15; k++) begin
            step(1);
            if (on_line !== 3'b010) dev++;
        end
        check("glitch on_line deviations", dev, 0);
        check("glitch steer", steer, 0);
        check("glitch pulses", chg_cnt - c0, 0);

        for (int i = 0; i < 13; i++) begin
            v   = tbl[i];
            c0  = chg_cnt;
            raw = v.raw;
            sb_q.push_back(v);
            step(12);
            e = sb_q.pop_front();
            check($sformatf("vec%0d on_line", i), on_line, e.on_line);
            check($sformatf("vec%0d steer", i), steer, e.steer);
            check($sformatf("vec%0d state", i), state, e.state);
            check($sformatf("vec%0d lost", i), lost, 0);
            check($sformatf("vec%0d pulses", i), chg_cnt - c0, e.pulses);
        end

        // Lost-line timeout from steer -1.
        raw = 3'b100;
        step(12);
        check("pre-hold steer", steer, -1);
        raw = 3'b111;
        step(7);
        check("hold entry state", state, 1);
        check("hold entry steer", steer, -2);
        check("hold entry chg", steer_chg, 1);
        step(999);
        check("hold last state", state, 1);
        check("hold last lost", lost, 0);
        step(1);
        check("lost state", state, 2);
        check("lost flag", lost, 1);
        check("lost steer", steer, 0);
        check("lost chg", steer_chg, 1);

        // Reacquire landing on the timeout edge: TRACK wins.
        raw = 3'b100;
        step(12);
        check("reacq track state", state, 0);
        raw = 3'b111;
        step(7);
        check("reacq hold steer", steer, -2);
        l0 = lost_cnt;
        step(993);
        raw = 3'b101;
        step(6);
        check("reacq pre state", state, 1);
        step(1);
        check("reacq state", state, 0);
        check("reacq steer", steer, 0);
        check("reacq chg", steer_chg, 1);
        step(2);
        check("reacq lost cycles", lost_cnt - l0, 0);

        // Five-sensor instance, fast debounce and short timeout.
        rst5 = 1'b0;
        step(3);
        check("n5 state e2", state5, 1);
        check("n5 steer e2", steer5, 0);
        step(1);
        check("n5 on_line e3", on_line5, 5'b10000);
        check("n5 steer e3", steer5, 4);
        check("n5 state e3", state5, 0);
        check("n5 chg e3", steer_chg5, 1);
        raw5 = 5'b11111;
        step(3);
        check("n5 on_line e2'", on_line5, 0);
        check("n5 state e2'", state5, 0);
        step(1);
        check("n5 hold state", state5, 1);
        check("n5 hold steer", steer5, 4);
        check("n5 hold chg", steer_chg5, 0);
        step(3);
        check("n5 hold last", state5, 1);
        step(1);
        check("n5 lost state", state5, 2);
        check("n5 lost flag", lost5, 1);
        check("n5 lost steer", steer5, 0);
        check("n5 lost chg", steer_chg5, 1);
        #2 rst5 = 1'b1;
        #1;
        check("n5 rst-lost state", state5, 0);
        check("n5 rst-lost lost", lost5, 0);
        check("n5 rst-lost steer", steer5, 0);
        check("n5 rst-lost chg", steer_chg5, 0);
        step(2);
        rst5 = 1'b0;
        step(1);
        check("n5 release hold", state5, 1);
        #2 rst5 = 1'b1;
        #1;
        check("n5 rst-hold state", state5, 0);
        check("n5 rst-hold steer", steer5, 0);
        check("n5 rst-hold on_line", on_line5, 0);
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
